// File: rtl/sar_readout_pkg.sv
// Shared types for the SAR readout path: word width, word type and serializer states.
package sar_readout_pkg;

  localparam int unsigned WORD_W = 10;

  typedef logic [0:WORD_W-1] word_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_t;

endpackage

// File: rtl/sar_sync_fifo.sv
// Single-clock circular FIFO; a push while full is only accepted alongside a pop.
module sar_sync_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORD_W = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [0:WORD_W-1]       i_data,
  output logic [0:WORD_W-1]       o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [0:WORD_W-1] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_wr;
  logic              w_rd;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_data  = r_mem[r_rptr];
  assign o_level = r_level;

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/sar_readout.sv
// Captures SAR conversion words on the CKO strobe, buffers them and ships each one
// MSB-first on a framed FRAME/SCLK/SDO link.
module sar_readout
  import sar_readout_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CLKDIV = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CKO,
  input  logic [0:WORD_W-1]      DATA,
  input  logic                   CLR_OVF,
  output logic                   FRAME,
  output logic                   SCLK,
  output logic                   SDO,
  output logic                   OVF,
  output logic [$clog2(DEPTH):0] LEVEL
);

  localparam int unsigned DIV_W = $clog2(2 * CLKDIV);
  localparam int unsigned BIT_W = $clog2(WORD_W);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKDIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLKDIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic             r_ovf;
  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;
  word_t            r_shreg;
  logic             r_frame;
  logic             r_sclk;
  logic             r_sdo;

  logic  w_push;
  logic  w_pop;
  logic  w_drop;
  logic  w_full;
  logic  w_empty;
  logic  w_pending;
  word_t w_head;

  assign w_push    = r_sync2 & ~r_sync3;
  assign w_pop     = (r_state == LOAD);
  assign w_drop    = w_push & w_full & ~w_pop;
  assign w_pending = ~w_empty;

  sar_sync_fifo #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (DATA),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (LEVEL)
  );

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_ovf   <= 1'b0;
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_frame <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdo   <= 1'b0;
    end else begin
      r_sync1 <= CKO;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (CLR_OVF) begin
        r_ovf <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          r_frame <= 1'b0;
          r_sclk  <= 1'b0;
          r_sdo   <= 1'b0;
          r_div   <= '0;
          r_bit   <= '0;
          if (w_pending) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_shreg <= w_head;
          r_frame <= 1'b1;
          r_sclk  <= 1'b0;
          r_sdo   <= w_head[0];
          r_div   <= '0;
          r_bit   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_frame <= 1'b1;
          r_sclk  <= (r_div >= DIV_HALF);
          r_sdo   <= r_shreg[r_bit];
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (r_bit == BIT_LAST) begin
              r_bit   <= '0;
              r_state <= GAP;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        GAP: begin
          r_frame <= 1'b0;
          r_sclk  <= 1'b0;
          r_sdo   <= 1'b0;
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            // Go straight to LOAD when work is queued so back-to-back words keep the word period.
            r_state <= w_pending ? LOAD : IDLE;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign FRAME = r_frame;
  assign SCLK  = r_sclk;
  assign SDO   = r_sdo;
  assign OVF   = r_ovf;

endmodule
